// File: rtl/psec5_counter_readout_sequencer.sv
// rtl/psec5_counter_readout_sequencer.sv - PSEC5 channel counter readout sequencer (serial fetch, 50-bit word stream)
// Optional feature macro: PSEC5_RDO_PADCHECK_EN adds the PAD_ERR port and pad-bit checking.
module psec5_counter_readout_sequencer #(
  parameter int NUM_CH    = 8,
  parameter int SCLK_HALF = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RD_REQ,
  input  logic [NUM_CH-1:0] CH_MASK,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        SELECT_REG,
  output logic [NUM_CH-1:0] LOAD_CNT_SER,
  output logic              SPI_CLK,
  input  logic [NUM_CH-1:0] CNT_SER,
  output logic [49:0]       DATA,
  output logic [3:0]        DATA_CH,
  output logic              DATA_VALID,
  input  logic              DATA_READY
`ifdef PSEC5_RDO_PADCHECK_EN
  ,
  output logic              PAD_ERR
`endif
);

`ifdef PSEC5_RDO_PADCHECK_EN
  localparam int SRW = 56;
`else
  localparam int SRW = 50;
`endif
  localparam logic [3:0] HALF_LAST = 4'(SCLK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_SCK_HI, S_SCK_LO, S_OUT, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [3:0]        ch_q, ch_d;
  logic [2:0]        byte_q, byte_d;
  logic [2:0]        bit_q, bit_d;
  logic [3:0]        half_q, half_d;
  logic [SRW-1:0]    sr_q, sr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              valid_q, valid_d;
  logic [2:0]        sel_q, sel_d;
  logic [NUM_CH-1:0] load_q, load_d;

  logic              ser_bit;
  logic [NUM_CH-1:0] mask_rest;
  logic [5:0]        bit_idx;

  function automatic logic [3:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [3:0] c);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      oh[i] = (c == 4'(i));
    end
    return oh;
  endfunction

  assign ser_bit   = |(CNT_SER & ch_onehot(ch_q));
  assign mask_rest = mask_q & ~ch_onehot(ch_q);
  assign bit_idx   = {byte_q, bit_q};

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    half_d  = half_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (RD_REQ) begin
          if (|CH_MASK) begin
            mask_d  = CH_MASK;
            ch_d    = lowest_ch(CH_MASK);
            byte_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_LOAD: state_d = S_GAP;
      S_GAP: begin
        bit_d   = '0;
        half_d  = '0;
        state_d = S_SCK_HI;
      end
      S_SCK_HI: begin
        if (half_q == HALF_LAST) begin
          // Pad bits beyond the stored width are simply not kept
          if (bit_idx < 6'(SRW)) sr_d[bit_idx] = ser_bit;
          half_d  = '0;
          state_d = S_SCK_LO;
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      S_SCK_LO: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bit_q == 3'd7) begin
            if (byte_q == 3'd6) begin
              state_d = S_OUT;
            end else begin
              byte_d  = byte_q + 3'd1;
              state_d = S_LOAD;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_SCK_HI;
          end
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      S_OUT: begin
        if (DATA_READY) begin
          mask_d = mask_rest;
          if (|mask_rest) begin
            ch_d    = lowest_ch(mask_rest);
            byte_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change glitch-free with it
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_FIN);
    sclk_d  = (state_d == S_SCK_HI);
    valid_d = (state_d == S_OUT);
    sel_d   = byte_d;
    load_d  = (state_d == S_LOAD) ? ch_onehot(ch_d) : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign SELECT_REG   = sel_q;
  assign LOAD_CNT_SER = load_q;
  assign SPI_CLK      = sclk_q;
  assign DATA_VALID   = valid_q;
  assign DATA         = valid_q ? sr_q[49:0] : '0;
  assign DATA_CH      = valid_q ? ch_q : '0;

`ifdef PSEC5_RDO_PADCHECK_EN
  logic sticky_q, sticky_d;
  logic pad_q, pad_d;

  // Sticky flag collects pad errors over one sweep and is shown during DONE
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == S_IDLE && RD_REQ) sticky_d = 1'b0;
    if (state_d == S_OUT && |sr_d[55:50]) sticky_d = 1'b1;
    pad_d = 1'b0;
    if (state_d == S_OUT) pad_d = |sr_d[55:50];
    else if (state_q == S_FIN) pad_d = sticky_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 1'b0;
      pad_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      pad_q    <= pad_d;
    end
  end

  assign PAD_ERR = pad_q;
`endif

endmodule

// File: tb/tb_psec5_counter_readout_sequencer.sv
// tb/tb_psec5_counter_readout_sequencer.sv - table-driven and randomized bench for the readout sequencer
// Channel blocks are modelled behaviourally; expected words come from a per-sweep scoreboard.
module tb_psec5_counter_readout_sequencer;
  localparam int NUM_CH = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              RD_REQ;
  logic [NUM_CH-1:0] CH_MASK;
  logic              BUSY, DONE, SPI_CLK, DATA_VALID, DATA_READY;
  logic [2:0]        SELECT_REG;
  logic [NUM_CH-1:0] LOAD_CNT_SER;
  logic [NUM_CH-1:0] CNT_SER;
  logic [49:0]       DATA;
  logic [3:0]        DATA_CH;

  logic              RD_REQ3, BUSY3, DONE3, SPI_CLK3, DATA_VALID3;
  logic [NUM_CH-1:0] CH_MASK3, LOAD_CNT_SER3;
  logic [2:0]        SELECT_REG3;
  logic [49:0]       DATA3;
  logic [3:0]        DATA_CH3;
`ifdef PSEC5_RDO_PADCHECK_EN
  logic              PAD_ERR, PAD_ERR3;
`endif

  always #5 CLK = ~CLK;

  psec5_counter_readout_sequencer #(.NUM_CH(NUM_CH), .SCLK_HALF(1)) dut (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .CH_MASK(CH_MASK), .BUSY(BUSY), .DONE(DONE),
    .SELECT_REG(SELECT_REG), .LOAD_CNT_SER(LOAD_CNT_SER), .SPI_CLK(SPI_CLK), .CNT_SER(CNT_SER),
    .DATA(DATA), .DATA_CH(DATA_CH), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY)
`ifdef PSEC5_RDO_PADCHECK_EN
    , .PAD_ERR(PAD_ERR)
`endif
  );

  psec5_counter_readout_sequencer #(.NUM_CH(NUM_CH), .SCLK_HALF(3)) dut3 (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ3), .CH_MASK(CH_MASK3), .BUSY(BUSY3), .DONE(DONE3),
    .SELECT_REG(SELECT_REG3), .LOAD_CNT_SER(LOAD_CNT_SER3), .SPI_CLK(SPI_CLK3), .CNT_SER('0),
    .DATA(DATA3), .DATA_CH(DATA_CH3), .DATA_VALID(DATA_VALID3), .DATA_READY(1'b1)
`ifdef PSEC5_RDO_PADCHECK_EN
    , .PAD_ERR(PAD_ERR3)
`endif
  );

  typedef struct { logic [3:0] ch; logic [55:0] w; } sb_t;
  typedef struct { logic [NUM_CH-1:0] mask; int mode; int exp_done; int exp_words; } vec_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  sb_t sb[$];
  logic exp_pad_any;
  vec_t vecs[6];

  // Behavioural channel blocks: a load latches the byte select, each SPI_CLK fall advances a bit
  logic [55:0]       word [NUM_CH];
  int                sel_m [NUM_CH];
  int                bidx [NUM_CH];
  logic              prev_sclk = 1'b0;
  logic [NUM_CH-1:0] cur_mask;
  int sclk_rises, load_cnt, sel_err, bad_load, overlap;

  always @(negedge CLK) begin
    if (SPI_CLK && !prev_sclk) sclk_rises++;
    if (!SPI_CLK && prev_sclk) for (int c = 0; c < NUM_CH; c++) bidx[c]++;
    prev_sclk = SPI_CLK;
    if (|LOAD_CNT_SER) begin
      if (SELECT_REG != 3'(load_cnt % 7)) sel_err++;
      if ((LOAD_CNT_SER & ~cur_mask) != '0 || $countones(LOAD_CNT_SER) != 1) bad_load++;
      if (SPI_CLK) overlap++;
      load_cnt++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (LOAD_CNT_SER[c]) begin
          sel_m[c] = int'(SELECT_REG);
          bidx[c]  = 0;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      int idx;
      idx = sel_m[c] * 8 + bidx[c];
      CNT_SER[c] = (bidx[c] < 8 && idx < 56) ? word[c][idx] : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
    cyc++;
  endtask

  task automatic issue_req(input logic [NUM_CH-1:0] m);
    sb.delete();
    exp_pad_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) begin
        sb.push_back('{ch: 4'(c), w: word[c]});
        exp_pad_any |= |word[c][55:50];
      end
    end
    cur_mask = m;
    sclk_rises = 0; load_cnt = 0; sel_err = 0; bad_load = 0; overlap = 0;
    RD_REQ  = 1'b1;
    CH_MASK = m;
    tick();
    RD_REQ  = 1'b0;
    CH_MASK = ~m;
    cyc = 1;
    chk("busy_cycle1", BUSY, 1);
  endtask

  // mode 0: always ready; 1: random ready; 2: always ready plus stray RD_REQ pulses
  task automatic run_until_done(input int mode, output int done_cyc, output int first_valid,
                                output int nwords);
    sb_t e;
    done_cyc = -1; first_valid = -1; nwords = 0;
    for (int budget = 0; budget < 6000; budget++) begin
      if (DONE) begin
        done_cyc = cyc;
        chk("busy_at_done", BUSY, 0);
`ifdef PSEC5_RDO_PADCHECK_EN
        chk("pad_at_done", PAD_ERR, exp_pad_any);
`endif
        break;
      end
      if (DATA_VALID && first_valid < 0) first_valid = cyc;
      DATA_READY = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mode == 2 && cyc < 100 && $urandom_range(0, 7) == 0) begin
        RD_REQ  = 1'b1;
        CH_MASK = NUM_CH'($urandom);
      end else begin
        RD_REQ = 1'b0;
      end
      if (DATA_VALID && DATA_READY) begin
        if (sb.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data", DATA, e.w[49:0]);
          chk("data_ch", DATA_CH, e.ch);
`ifdef PSEC5_RDO_PADCHECK_EN
          chk("pad_with_word", PAD_ERR, |e.w[55:50]);
`endif
          nwords++;
        end
      end
      tick();
    end
    RD_REQ = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("words_left", sb.size(), 0);
  endtask

  task automatic rand_words();
    for (int c = 0; c < NUM_CH; c++) begin
      word[c] = 56'({$urandom, $urandom});
      word[c][55:50] = ($urandom_range(0, 1) != 0) ? 6'h01 : 6'h00;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  initial begin
    int d, fv, nw, r1, f1, r2;
    logic p, stable;
    logic [49:0] snap_d;
    logic [3:0] snap_ch;
    sb_t e;

    vecs[0] = '{mask: 8'h01, mode: 0, exp_done: 129,  exp_words: 1};
    vecs[1] = '{mask: 8'h82, mode: 0, exp_done: 256,  exp_words: 2};
    vecs[2] = '{mask: 8'h00, mode: 0, exp_done: 2,    exp_words: 0};
    vecs[3] = '{mask: 8'hFF, mode: 0, exp_done: 1018, exp_words: 8};
    vecs[4] = '{mask: 8'h04, mode: 2, exp_done: 129,  exp_words: 1};
    vecs[5] = '{mask: 8'h18, mode: 0, exp_done: 256,  exp_words: 2};

    for (int c = 0; c < NUM_CH; c++) begin sel_m[c] = 0; bidx[c] = 8; end
    rand_words();
    word[0] = {6'h00, 10'h200, 10'h3FF, 10'h001, 10'h2AA, 10'h155};
    word[1][55:50] = 6'h01;
    word[7][55:50] = 6'h00;
    cur_mask = '0;

    RST = 1'b1; RD_REQ = 1'b0; CH_MASK = '0; DATA_READY = 1'b0;
    RD_REQ3 = 1'b0; CH_MASK3 = '0;
    tick(); tick();
    chk("reset_ctrl", {BUSY, DONE, SELECT_REG, LOAD_CNT_SER, SPI_CLK, DATA_CH, DATA_VALID}, 0);
    chk("reset_data", DATA, 0);
`ifdef PSEC5_RDO_PADCHECK_EN
    chk("reset_pad", PAD_ERR, 0);
`endif
    RST = 1'b0;
    tick();

    // SPI_CLK timing with SCLK_HALF=3
    RD_REQ3 = 1'b1; CH_MASK3 = 8'h01;
    tick();
    RD_REQ3 = 1'b0; cyc = 1;
    r1 = -1; f1 = -1; r2 = -1; p = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (SPI_CLK3 && !p) begin
        if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
      end
      if (!SPI_CLK3 && p && f1 < 0) f1 = cyc;
      p = SPI_CLK3;
      tick();
    end
    chk("sclk3_first_rise", r1, 3);
    chk("sclk3_high_len", f1 - r1, 3);
    chk("sclk3_period", r2 - r1, 6);

    // Table of always-ready sweeps
    for (int v = 0; v < 6; v++) begin
      issue_req(vecs[v].mask);
      run_until_done(vecs[v].mode, d, fv, nw);
      chk("done_cycle", d, vecs[v].exp_done);
      chk("word_count", nw, vecs[v].exp_words);
      if (vecs[v].exp_words > 0) chk("first_valid_cycle", fv, 127);
      chk("sclk_pulses", sclk_rises, 56 * vecs[v].exp_words);
      chk("load_pulses", load_cnt, 7 * vecs[v].exp_words);
      chk("select_seq_errs", sel_err, 0);
      chk("stray_loads", bad_load, 0);
      chk("load_sclk_overlap", overlap, 0);
      tick(); tick();
    end

    // Randomized masks, counters and back-pressure
    for (int r = 0; r < 6; r++) begin
      logic [NUM_CH-1:0] m;
      rand_words();
      m = NUM_CH'($urandom_range(1, 255));
      issue_req(m);
      run_until_done(1, d, fv, nw);
      chk("rand_word_count", nw, $countones(m));
      chk("rand_sclk_pulses", sclk_rises, 56 * $countones(m));
      chk("rand_select_errs", sel_err + bad_load + overlap, 0);
      tick();
    end

    // Back-pressure at the first OUT, then resume
    DATA_READY = 1'b0;
    issue_req(8'h03);
    while (!DATA_VALID && cyc < 300) tick();
    chk("bp_valid_cycle", cyc, 127);
    snap_d = DATA; snap_ch = DATA_CH; stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!DATA_VALID || DATA !== snap_d || DATA_CH !== snap_ch || SPI_CLK || |LOAD_CNT_SER)
        stable = 1'b0;
      tick();
    end
    chk("bp_stall_stable", stable, 1);
    e = sb.pop_front();
    chk("bp_data", DATA, e.w[49:0]);
    chk("bp_data_ch", DATA_CH, e.ch);
    DATA_READY = 1'b1;
    tick();
    chk("bp_next_load", LOAD_CNT_SER, 8'h02);
    chk("bp_valid_dropped", DATA_VALID, 0);
    run_until_done(0, d, fv, nw);
    chk("bp_rest_words", nw, 1);

    // Reset during byte 3 of channel 0, then a clean restart
    tick();
    issue_req(8'h01);
    while (cyc < 60) tick();
    RST = 1'b1;
    #1;
    chk("midrst_ctrl", {BUSY, DONE, SELECT_REG, LOAD_CNT_SER, SPI_CLK, DATA_CH, DATA_VALID}, 0);
    chk("midrst_data", DATA, 0);
    tick(); tick();
    RST = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (DONE || BUSY) stable = 1'b0;
      tick();
    end
    chk("midrst_quiet", stable, 1);
    issue_req(8'h01);
    run_until_done(0, d, fv, nw);
    chk("restart_done", d, 129);
    chk("restart_first_valid", fv, 127);
    chk("restart_select_errs", sel_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/psec5_counter_readout_sequencer.md
Name: psec5_counter_readout_sequencer

Overview:
Multi-channel readout controller for the PSEC5 per-channel digital blocks' serial counter interface. On request it walks every enabled channel in ascending order. For each channel it steps SELECT_REG 0..6, pulses that channel's LOAD_CNT_SER, clocks 8 bits out on SPI_CLK and samples CNT_SER. It then presents the reassembled 50-bit counter word {CE,CD,CC,CB,CA} on a valid/ready stream to the chip-level serializer.

Parameters:
NUM_CH, 8, number of channel blocks served (1..16)
SCLK_HALF, 1, CLK cycles per SPI_CLK half-period (1..15)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
RD_REQ  input  1  readout request, sampled only in IDLE
CH_MASK  input  NUM_CH  enabled channels; latched when RD_REQ is accepted
BUSY  output  1  high from acceptance until DONE
DONE  output  1  one-cycle pulse when the sweep completes
SELECT_REG  output  3  shared byte select to all channel blocks
LOAD_CNT_SER  output  NUM_CH  one-hot per-channel load strobe
SPI_CLK  output  1  shared shift clock to all channel blocks
CNT_SER  input  NUM_CH  per-channel serial data
DATA  output  50  {CE,CD,CC,CB,CA}, 10 bits each
DATA_CH  output  4  channel index of DATA
DATA_VALID  output  1  word available
DATA_READY  input  1  consumer accepts on DATA_VALID&&DATA_READY
PAD_ERR  output  1  only with PSEC5_RDO_PADCHECK_EN (see below)

Behaviour:
- Reset values: all outputs 0; state IDLE; latched mask, shift register and byte counter cleared.
- Reset mid-operation: sweep aborted, partial data discarded, no DONE pulse.
- States: IDLE, LOAD, GAP, SCK_HI, SCK_LO, OUT, FIN.
- IDLE:
  - RD_REQ=1 with CH_MASK!=0: latch mask, pick the lowest set bit as channel, byte=0, go to LOAD.
  - RD_REQ=1 with CH_MASK==0: go to FIN (DONE on the next cycle, no words).
  - RD_REQ is ignored in every other state.
- LOAD (1 cycle): SELECT_REG=byte; LOAD_CNT_SER[ch]=1; SPI_CLK=0.
- GAP (1 cycle): all LOAD_CNT_SER=0; SPI_CLK=0; SELECT_REG held.
- SCK_HI (SCLK_HALF cycles): SPI_CLK=1.
  - On the final CLK edge of SCK_HI, sample CNT_SER[ch] into bit position byte*8+bitcnt (LSB first).
- SCK_LO (SCLK_HALF cycles): SPI_CLK=0.
  - After bit 7: byte<6 -> byte+1, go to LOAD; byte==6 -> go to OUT.
  - Otherwise bitcnt+1, go to SCK_HI.
- SPI_CLK, LOAD_CNT_SER and SELECT_REG are registered outputs, glitch-free.
- LOAD_CNT_SER and SPI_CLK are never high in the same cycle.
- OUT:
  - DATA=assembled[49:0], DATA_CH=ch, DATA_VALID=1.
  - DATA, DATA_CH and DATA_VALID are held stable until the handshake completes (back-pressure stalls the sweep indefinitely).
  - On handshake: clear ch's mask bit; go to LOAD with the next-higher enabled channel and byte=0, else go to FIN.
- FIN (1 cycle): DONE=1, BUSY=0 next cycle, return to IDLE.
- Timing, SCLK_HALF=1, RD_REQ accepted at edge 0:
  - First LOAD at cycle 1; each byte takes 18 cycles; 7 bytes occupy cycles 1..126.
  - DATA_VALID rises at cycle 127.
  - The next channel's LOAD follows the cycle after the handshake.
- Assembled word is 56 bits; bits [55:50] are pad and are dropped from DATA.
- DATA_CH is zero-extended; channels at index >=NUM_CH do not exist.

Optional Feature:
PSEC5_RDO_PADCHECK_EN:
- Defined:
  - PAD_ERR is asserted with DATA_VALID when assembled[55:50]!=0, held and cleared with the word.
  - Any nonzero pad also sets a sticky internal flag, reported as PAD_ERR=1 during the DONE cycle; the flag is cleared on the next accepted RD_REQ.
- Undefined: the PAD_ERR port is absent; pad bits are ignored.

Test Plan:
- Single channel, setup:
  - CH_MASK=0x01, model counters CA=0x155, CB=0x2AA, CC=0x001, CD=0x3FF, CE=0x200, DATA_READY=1.
  - Expected: DATA=0x200_3FF_001_2AA_155 packed, DATA_CH=0, DATA_VALID at cycle 127, DONE at cycle 129.
  - Exactly 56 SPI_CLK pulses; LOAD_CNT_SER[0] pulses 7 times with SELECT_REG 0..6.
- Sparse mask: CH_MASK=0x82 with distinct counters -> words for ch1 then ch7, one DONE; LOAD_CNT_SER never asserts for other channels.
- Back-pressure: DATA_READY=0 for 50 cycles at first OUT -> DATA/DATA_CH stable, SPI_CLK=0, no LOAD; sweep resumes the cycle after the handshake.
- Empty mask / busy request: CH_MASK=0 -> DONE 2 cycles after RD_REQ, no DATA_VALID; RD_REQ pulses during a sweep are ignored.
- Reset mid-shift: assert RST during byte 3 of ch0 -> all outputs 0 immediately; a new RD_REQ after release restarts cleanly at byte 0.
- Pad check (macro defined): model pad bits=0x01 -> PAD_ERR=1 with DATA_VALID and at DONE; pad=0 -> PAD_ERR=0. SCLK_HALF=3 -> SPI_CLK period of 6 cycles.
